// File: rtl/float_mac_seq_if.sv
// Operand/result stream bundle for the dot-product sequencer.
// master = operand source + result consumer, slave = the sequencer.
interface float_mac_seq_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      a;
  logic [31:0]      b;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic             busy;

  modport master (
    output start, len, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  start, len, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/float_mac_seq.sv
// Single-precision dot-product sequencer with its combinational binary32
// multiplier and adder. Subnormal inputs are read as zero and results that
// fall below the normal range are returned as signed zero; rounding is
// round-to-nearest-even.

module float_mul_gc (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);
  logic               w_sign;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [47:0]        w_prod;
  logic signed [9:0]  w_exp;
  logic signed [9:0]  w_ef;
  logic [22:0]        w_mant;
  logic               w_g, w_st, w_inc;
  logic [32:0]        w_rnd;

  assign w_sign   = i_a[31] ^ i_b[31];
  assign w_a_zero = (i_a[30:23] == 8'd0);
  assign w_b_zero = (i_b[30:23] == 8'd0);
  assign w_a_inf  = (i_a[30:23] == 8'hff) && (i_a[22:0] == 23'd0);
  assign w_b_inf  = (i_b[30:23] == 8'hff) && (i_b[22:0] == 23'd0);
  assign w_a_nan  = (i_a[30:23] == 8'hff) && (i_a[22:0] != 23'd0);
  assign w_b_nan  = (i_b[30:23] == 8'hff) && (i_b[22:0] != 23'd0);
  assign w_prod   = 48'({1'b1, i_a[22:0]}) * 48'({1'b1, i_b[22:0]});

  // Normalise the 48-bit significand product, round, then pick special cases.
  always_comb begin
    w_exp = $signed(10'(i_a[30:23])) + $signed(10'(i_b[30:23])) - 10'sd127
            + (w_prod[47] ? 10'sd1 : 10'sd0);
    if (w_prod[47]) begin
      w_mant = w_prod[46:24];
      w_g    = w_prod[23];
      w_st   = |w_prod[22:0];
    end else begin
      w_mant = w_prod[45:23];
      w_g    = w_prod[22];
      w_st   = |w_prod[21:0];
    end
    w_inc = w_g & (w_st | w_mant[0]);
    // A mantissa carry ripples straight into the exponent field.
    w_rnd = {w_exp, w_mant} + 33'(w_inc);
    w_ef  = w_rnd[32:23];
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      o_p = 32'h7fc00000;
    else if (w_a_inf || w_b_inf)
      o_p = {w_sign, 8'hff, 23'd0};
    else if (w_a_zero || w_b_zero)
      o_p = {w_sign, 31'd0};
    else if (w_ef >= 10'sd255)
      o_p = {w_sign, 8'hff, 23'd0};
    else if (w_ef <= 10'sd0)
      o_p = {w_sign, 31'd0};
    else
      o_p = {w_sign, w_ef[7:0], w_rnd[22:0]};
  end
endmodule

module float_add_gc (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_s
);
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [31:0]        w_x, w_y;
  logic [7:0]         w_d;
  logic [49:0]        w_wx, w_wy, w_sum;
  logic [48:0]        w_norm;
  logic [5:0]         w_lz;
  logic               w_found;
  logic signed [9:0]  w_exp;
  logic signed [9:0]  w_ef;
  logic               w_g, w_st, w_inc;
  logic [32:0]        w_rnd;

  assign w_a_zero = (i_a[30:23] == 8'd0);
  assign w_b_zero = (i_b[30:23] == 8'd0);
  assign w_a_inf  = (i_a[30:23] == 8'hff) && (i_a[22:0] == 23'd0);
  assign w_b_inf  = (i_b[30:23] == 8'hff) && (i_b[22:0] == 23'd0);
  assign w_a_nan  = (i_a[30:23] == 8'hff) && (i_a[22:0] != 23'd0);
  assign w_b_nan  = (i_b[30:23] == 8'hff) && (i_b[22:0] != 23'd0);

  // Align the smaller magnitude, add/subtract exactly, normalise and round.
  always_comb begin
    w_x = (i_a[30:0] >= i_b[30:0]) ? i_a : i_b;
    w_y = (i_a[30:0] >= i_b[30:0]) ? i_b : i_a;
    w_d = w_x[30:23] - w_y[30:23];
    w_wx = {1'b0, 1'b1, w_x[22:0], 25'd0};
    // Beyond 25 places the smaller operand is under a quarter ulp of the
    // larger, so a lone sticky bit rounds identically to the exact value.
    w_wy = (w_d > 8'd25) ? 50'd1 : ({1'b0, 1'b1, w_y[22:0], 25'd0} >> w_d);
    w_sum = (w_x[31] ^ w_y[31]) ? (w_wx - w_wy) : (w_wx + w_wy);
    w_lz = 6'd0;
    w_found = 1'b0;
    for (int i = 49; i >= 0; i--) begin
      if (!w_found && w_sum[i]) begin
        w_lz = 6'(49 - i);
        w_found = 1'b1;
      end
    end
    w_norm = 49'(w_sum << w_lz);
    w_exp  = $signed(10'(w_x[30:23])) + 10'sd1 - $signed(10'(w_lz));
    w_g    = w_norm[25];
    w_st   = |w_norm[24:0];
    w_inc  = w_g & (w_st | w_norm[26]);
    w_rnd  = {w_exp, w_norm[48:26]} + 33'(w_inc);
    w_ef   = w_rnd[32:23];
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (i_a[31] != i_b[31])))
      o_s = 32'h7fc00000;
    else if (w_a_inf)
      o_s = i_a;
    else if (w_b_inf)
      o_s = i_b;
    else if (w_a_zero && w_b_zero)
      o_s = {i_a[31] & i_b[31], 31'd0};
    else if (w_a_zero)
      o_s = i_b;
    else if (w_b_zero)
      o_s = i_a;
    else if (w_sum == 50'd0)
      o_s = 32'h0;
    else if (w_ef >= 10'sd255)
      o_s = {w_x[31], 8'hff, 23'd0};
    else if (w_ef <= 10'sd0)
      o_s = {w_x[31], 31'd0};
    else
      o_s = {w_x[31], w_ef[7:0], w_rnd[22:0]};
  end
endmodule

// state | meaning
// IDLE  | waiting for start; len captured and accumulator cleared on start
// RUN   | accepting operand pairs, one per cycle when in_valid is high
// DRAIN | last product still in flight; fold it into the accumulator
// DONE  | result presented until the consumer takes it
module float_mac_seq #(
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  float_mac_seq_if.slave    bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_count, r_len;
  logic [31:0]      r_acc, r_prod;
  logic             r_prod_v;
  logic             w_accept, w_last;
  logic             w_in_ready, w_out_valid, w_busy;
  logic [31:0]      w_prod, w_sum;

  float_mul_gc u_mul (.i_a(bus.a), .i_b(bus.b), .o_p(w_prod));
  float_add_gc u_add (.i_a(r_acc), .i_b(r_prod), .o_s(w_sum));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.result    = r_acc;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = (r_state != S_IDLE);
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (bus.len != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        w_in_ready = 1'b1;
        w_accept   = bus.in_valid;
        w_last     = (r_count == r_len - 1'b1);
        if (w_accept && w_last) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Element counter, product pipeline register and accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_len    <= '0;
      r_acc    <= 32'h0;
      r_prod   <= 32'h0;
      r_prod_v <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len    <= bus.len;
            r_count  <= '0;
            r_acc    <= 32'h0;
            r_prod_v <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_prod_v) r_acc <= w_sum;
          if (w_accept) begin
            r_prod   <= w_prod;
            r_prod_v <= 1'b1;
            r_count  <= r_count + 1'b1;
          end else begin
            r_prod_v <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_prod_v) r_acc <= w_sum;
          r_prod_v <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
